// File: rtl/tlb_wport_ctrl_pkg.sv
// Shared constants and encodings for the TLB write-port controller.
package tlb_wport_ctrl_pkg;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  localparam logic [IDXW-1:0] IDX_ZERO = '0;
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = '1;

  // Request opcodes; 2'b11 is reserved and completes as a no-op.
  typedef enum logic [1:0] {
    OP_WR     = 2'b00,
    OP_FILL   = 2'b01,
    OP_INVALL = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_SWEEP = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_4_16.sv
// 4-bit index to 16-bit one-hot decoder.
module decoder_4_16 (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // Single bit set at the position selected by idx.
  always_comb begin
    onehot = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/encoder_16_check.sv
// Flags a 16-bit strobe vector that has more than one bit set.
module encoder_16_check (
  input  logic [15:0] vec,
  output logic        multi_hot
);

  // Equivalent to OR over all pairs vec[i] & vec[j] (i<j): a bit set after
  // any earlier bit was already seen means at least two bits are set.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < 16; i++) begin
      multi_hot = multi_hot | (seen & vec[i]);
      seen      = seen | vec[i];
    end
  end

endmodule

// File: rtl/tlb_wport_ctrl.sv
// TLB write-port controller: turns WR / FILL / INVALL requests into a
// registered one-hot write strobe for the 16-entry TLB array.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_op/req_index are sampled on that edge. The
// requester holds req_valid (and its payload) until that edge. req_ready is
// 1 only in IDLE.
module tlb_wport_ctrl
  import tlb_wport_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [IDXW-1:0]   req_index,
  output logic [TLBNUM-1:0] entry_we,
  output logic              entry_clr,
  output logic              done,
  output logic [IDXW-1:0]   done_index,
  output logic              err
);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   fill_ctr_q, fill_ctr_d;
  logic [IDXW-1:0]   sweep_ctr_q, sweep_ctr_d;
  logic [TLBNUM-1:0] entry_we_q, entry_we_d;
  logic              entry_clr_q, entry_clr_d;
  logic              done_q, done_d;
  logic [IDXW-1:0]   done_index_q, done_index_d;
  logic              err_q, err_d;

  logic              accept;
  logic              dec_en;
  logic [IDXW-1:0]   dec_idx;
  logic [TLBNUM-1:0] dec_onehot;
  logic              multi_hot;

  // The decoder sees the index that will be active in the next cycle, so the
  // registered strobe lines up with the state it belongs to.
  decoder_4_16 u_dec (
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  encoder_16_check u_chk (
    .vec       (entry_we_q),
    .multi_hot (multi_hot)
  );

  assign accept = req_valid && (state_q == ST_IDLE);

  // Next-state and next-output logic for the FSM and counters.
  always_comb begin
    state_d      = state_q;
    fill_ctr_d   = fill_ctr_q + IDX_ONE;
    sweep_ctr_d  = sweep_ctr_q;
    dec_en       = 1'b0;
    dec_idx      = IDX_ZERO;
    entry_clr_d  = 1'b0;
    done_d       = 1'b0;
    done_index_d = IDX_ZERO;
    err_d        = err_q | multi_hot;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_WR: begin
              state_d      = ST_WRITE;
              dec_en       = 1'b1;
              dec_idx      = req_index;
              done_d       = 1'b1;
              done_index_d = req_index;
            end
            OP_FILL: begin
              state_d      = ST_WRITE;
              dec_en       = 1'b1;
              dec_idx      = fill_ctr_q;
              done_d       = 1'b1;
              done_index_d = fill_ctr_q;
            end
            OP_INVALL: begin
              state_d     = ST_SWEEP;
              sweep_ctr_d = IDX_ZERO;
              dec_en      = 1'b1;
              dec_idx     = IDX_ZERO;
              entry_clr_d = 1'b1;
            end
            default: begin
              // Reserved op: acknowledge with a bare done pulse.
              done_d = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_SWEEP: begin
        if (sweep_ctr_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          sweep_ctr_d = sweep_ctr_q + IDX_ONE;
          dec_en      = 1'b1;
          dec_idx     = sweep_ctr_d;
          entry_clr_d = 1'b1;
          if (sweep_ctr_d == IDX_LAST) begin
            done_d       = 1'b1;
            done_index_d = IDX_LAST;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    entry_we_d = dec_en ? dec_onehot : '0;
  end

  // All state and outputs; reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_ctr_q   <= '0;
      sweep_ctr_q  <= '0;
      entry_we_q   <= '0;
      entry_clr_q  <= 1'b0;
      done_q       <= 1'b0;
      done_index_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_ctr_q   <= fill_ctr_d;
      sweep_ctr_q  <= sweep_ctr_d;
      entry_we_q   <= entry_we_d;
      entry_clr_q  <= entry_clr_d;
      done_q       <= done_d;
      done_index_q <= done_index_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign entry_we   = entry_we_q;
  assign entry_clr  = entry_clr_q;
  assign done       = done_q;
  assign done_index = done_index_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tlb_wport_ctrl.sv
// Directed bench for the TLB write-port controller.
module tb_tlb_wport_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_index;
  logic [15:0] entry_we;
  logic        entry_clr;
  logic        done;
  logic [3:0]  done_index;
  logic        err;

  int errors;
  int checks;

  tlb_wport_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_index  (req_index),
    .entry_we   (entry_we),
    .entry_clr  (entry_clr),
    .done       (done),
    .done_index (done_index),
    .err        (err)
  );

  // Clock: rising edges at 5, 15, 25 ...; bench drives and samples on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_we;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_index = 4'd0;
    tick();
    tick();

    // Reset values
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(entry_we), 32'h0);
    chk("rst_clr", 32'(entry_clr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_didx", 32'(done_index), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // WR index 9 right after reset release
    reset     = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_index = 4'd9;
    tick();
    req_valid = 1'b0;
    chk("wr9_we", 32'(entry_we), 32'h0200);
    chk("wr9_clr", 32'(entry_clr), 32'd0);
    chk("wr9_done", 32'(done), 32'd1);
    chk("wr9_didx", 32'(done_index), 32'd9);
    chk("wr9_ready0", 32'(req_ready), 32'd0);
    tick();
    chk("wr9_ready1", 32'(req_ready), 32'd1);
    chk("wr9_done0", 32'(done), 32'd0);
    chk("wr9_we0", 32'(entry_we), 32'h0);

    // FILL accepted on the 6th edge after release -> fill_ctr = 5
    do_reset();
    repeat (5) tick();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_index = 4'd12;
    tick();
    req_valid = 1'b0;
    chk("fill5_we", 32'(entry_we), 32'h0020);
    chk("fill5_didx", 32'(done_index), 32'd5);
    chk("fill5_done", 32'(done), 32'd1);
    // Second FILL 18 edges later: 5 + 18 = 23 -> wraps to 7
    repeat (17) tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("fill7_we", 32'(entry_we), 32'h0080);
    chk("fill7_didx", 32'(done_index), 32'd7);
    tick();

    // INVALL full sweep, req_valid held high throughout
    req_valid = 1'b1;
    req_op    = 2'b10;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_we = 16'h0001 << i;
      chk($sformatf("sweep%0d_we", i), 32'(entry_we), 32'(exp_we));
      chk($sformatf("sweep%0d_clr", i), 32'(entry_clr), 32'd1);
      chk($sformatf("sweep%0d_done", i), 32'(done), (i == 15) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d_ready", i), 32'(req_ready), 32'd0);
      if (i == 15) chk("sweep_didx", 32'(done_index), 32'd15);
      if (i != 15) tick();
    end
    tick();
    chk("sweep_end_ready", 32'(req_ready), 32'd1);
    chk("sweep_end_we", 32'(entry_we), 32'h0);
    chk("sweep_end_clr", 32'(entry_clr), 32'd0);
    chk("sweep_end_done", 32'(done), 32'd0);
    req_valid = 1'b0;
    tick();

    // Reset asserted on the 7th sweep cycle
    req_valid = 1'b1;
    req_op    = 2'b10;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("abort_pre_we", 32'(entry_we), 32'h0040);
    #1 reset = 1'b1;
    #1;
    chk("abort_we", 32'(entry_we), 32'h0);
    chk("abort_clr", 32'(entry_clr), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    reset     = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_index = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("wr3_we", 32'(entry_we), 32'h0008);
    chk("wr3_done", 32'(done), 32'd1);
    chk("wr3_didx", 32'(done_index), 32'd3);
    chk("wr3_clr", 32'(entry_clr), 32'd0);
    tick();
    chk("wr3_after_done", 32'(done), 32'd0);

    // Reserved op 11
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_index = 4'd6;
    tick();
    req_valid = 1'b0;
    chk("rsvd_done", 32'(done), 32'd1);
    chk("rsvd_we", 32'(entry_we), 32'h0);
    chk("rsvd_didx", 32'(done_index), 32'd0);
    chk("rsvd_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rsvd_done0", 32'(done), 32'd0);

    // Back-to-back WR stream: one accept every 2 cycles
    req_valid = 1'b1;
    req_op    = 2'b00;
    for (int k = 0; k < 4; k++) begin
      req_index = 4'(k * 4 + 1);
      exp_we    = 16'h0001 << (k * 4 + 1);
      tick();
      chk($sformatf("b2b%0d_we", k), 32'(entry_we), 32'(exp_we));
      chk($sformatf("b2b%0d_didx", k), 32'(done_index), 32'(k * 4 + 1));
      chk($sformatf("b2b%0d_busy", k), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("b2b%0d_gap_done", k), 32'(done), 32'd0);
      chk($sformatf("b2b%0d_gap_we", k), 32'(entry_we), 32'h0);
      chk($sformatf("b2b%0d_ready", k), 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    chk("err_clean", 32'(err), 32'd0);

    // Corrupt the strobe register: two bits set
    tick();
    force dut.entry_we_q = 16'h0005;
    tick();
    release dut.entry_we_q;
    chk("err_set", 32'(err), 32'd1);
    tick();
    chk("err_sticky_we", 32'(entry_we), 32'h0);
    repeat (3) tick();
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_wport_ctrl.md
# tlb_wport_ctrl

Write-port controller for the 16-entry TLB, turning a 4-bit entry index into a registered one-hot write enable; it is the write side of the TLB array, and complements the search path that turns a one-hot hit vector back into an index. It serves TLBWR (explicit index), TLBFILL (pseudo-random index from a free-running counter) and invalidate-all (a 16-cycle clearing sweep). A valid/ready handshake connects it to the CSR/exception stage. It also self-checks that the enable vector it drives stays one-hot.

## Interface
- TLBNUM, 16: number of TLB entries; fixed power of two.
- IDXW, 4: index width, log2(TLBNUM).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces every register and output to its reset value immediately.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; reset 1.
- req_op  in  2  00 WR, 01 FILL, 10 INVALL, 11 reserved.
- req_index  in  IDXW  target entry for WR; ignored for other ops.
- entry_we  out  TLBNUM  one-hot write/clear strobe to the TLB array; reset 0.
- entry_clr  out  1  qualifies entry_we as "clear valid bit" rather than "write data"; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- done_index  out  IDXW  index of the last entry written; valid with done; reset 0.
- err  out  1  sticky; set if entry_we ever has more than one bit set; reset 0.

## Operation
- Accept when req_valid & req_ready; req_op and the index are captured in that cycle.
- fill_ctr: a 4-bit free-running counter, reset 0, incrementing every cycle and wrapping 15 -> 0. A FILL uses the fill_ctr value in the accept cycle.
- FSM states: IDLE, WRITE, SWEEP.
  - IDLE: req_ready=1. Accepted WR/FILL -> WRITE. Accepted INVALL -> SWEEP with sweep_ctr=0. Accepted op 11 -> stays IDLE, pulses done next cycle with entry_we=0 and done_index=0.
  - WRITE: req_ready=0. entry_we = decode(captured index), entry_clr=0, done=1, done_index=captured index. Next state IDLE.
  - SWEEP: req_ready=0, entry_clr=1, entry_we = decode(sweep_ctr). sweep_ctr increments each cycle. When sweep_ctr==15: done=1, done_index=15, next state IDLE. No wrap beyond 15.
- entry_we, entry_clr, done and done_index are registered; no combinational path from req_* to them.
- err = OR over all bit pairs of entry_we (i<j) of we[i]&we[j]; once set it stays set until reset.
- A request presented while req_ready=0 is not accepted. The requester must hold req_valid until the handshake completes.

## Timing
- WR/FILL: accept at cycle N -> entry_we and done at N+1 -> req_ready high again at N+2. Back-to-back writes therefore accept every 2 cycles.
- INVALL: accept at N -> entry_we[0] at N+1 ... entry_we[15] at N+16, done at N+16, req_ready at N+17.
- fill_ctr keeps counting during WRITE and SWEEP.
- Reset mid-sweep or mid-write: outputs drop to reset values asynchronously. The sweep is abandoned, with no done and no resume.
- Reset released: first accept is possible on the first rising edge with reset low.

## Structure
- Shared package: TLBNUM, IDXW, op encodings (OP_WR, OP_FILL, OP_INVALL), FSM state encoding.
- Instantiate the existing decoder_4_16 for index -> one-hot, and encoder_16_check for err generation. No new sub-module.
- Muxing: the decoder input is the captured index in WRITE and sweep_ctr in SWEEP. Its output is gated to 0 in IDLE.

## Test plan
- WR with index 9 after reset -> next cycle entry_we=0x0200, entry_clr=0, done=1, done_index=9; req_ready 0 then 1.
- FILL accepted 5 cycles after reset release (fill_ctr=5) -> entry_we=0x0020, done_index=5. A second FILL 18 cycles later gives the wrapped value.
- INVALL -> 16 consecutive cycles of entry_we=0x0001..0x8000 with entry_clr=1. done only on the 0x8000 cycle, done_index=15. req_valid held high meanwhile is not accepted.
- Reset asserted on the 7th sweep cycle -> entry_we=0, entry_clr=0, req_ready=1 immediately (asynchronous); no done. After release, a WR with index 3 works normally.
- op 11 -> done pulse with entry_we=0. Continuous back-to-back WR stream -> one accept per 2 cycles. err stays 0 across all tests.
- Forced entry_we corruption (force two bits) -> err rises and remains 1 until reset.
